// File: rtl/memory_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : memory_pkg
//  Purpose : Shared constants and types for the sample-memory writer and
//            playback reader (bus widths, memory depth, reader FSM encoding,
//            default gain format and read timeout).
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package memory_pkg;

  // Sample memory geometry shared by writer and reader
  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 16;
  localparam int MEM_DEPTH  = 65536;

  // Writer-side constants
  localparam logic [ADDR_WIDTH-1:0] WRITER_ADDR_RESET = '0;
  localparam logic [ADDR_WIDTH-1:0] WRITER_ADDR_LAST  = ADDR_WIDTH'(MEM_DEPTH - 1);

  // Reader defaults: unsigned Q8.8 gain, ~255-cycle memory timeout
  localparam int DEFAULT_GAIN_FRAC_BITS = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  // Playback reader FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_SCALE = 2'd2,
    ST_OUT   = 2'd3
  } reader_state_t;

endpackage : memory_pkg
`default_nettype wire

// File: rtl/sample_tick_sync.sv
`default_nettype none
// ============================================================================
//  Module  : sample_tick_sync
//  Purpose : Brings the asynchronous sample-rate clock into the clk domain
//            with a 2-FF synchronizer and emits a one-cycle tick on each
//            synchronized rising edge.
//  Ports   : clk       - system clock
//            rst       - asynchronous active-high reset
//            async_in  - asynchronous sample-rate clock
//            tick      - one-cycle pulse per rising edge of async_in
//  Rev     : 1.0  initial release
// ============================================================================
module sample_tick_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic tick
);

  logic       r_meta;
  logic       r_sync;
  logic       r_prev;
  logic [2:0] r_fill;

  // r_fill marks which pipeline stages hold a genuinely sampled value since
  // reset release. Edge detection is enabled only once r_prev is real, so a
  // level that was already high during reset never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      r_fill <= 3'b000;
    end else begin
      r_meta <= async_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_fill <= {r_fill[1:0], 1'b1};
    end
  end

  assign tick = r_fill[2] & r_sync & ~r_prev;

endmodule : sample_tick_sync
`default_nettype wire

// File: rtl/playback_reader.sv
`default_nettype none
// ============================================================================
//  Module  : playback_reader
//  Purpose : On each sample-rate tick, reads one delayed sample from the
//            circular sample memory, applies an unsigned Q8.8 gain with
//            saturation and presents it with a one-cycle valid pulse.
//  Ports   : clk, rst              - clock, asynchronous active-high reset
//            adc_clock             - asynchronous sample-rate clock
//            loop                  - playback enable
//            write_addr            - current writer address
//            delay_reverb          - read offset behind write_addr
//            loop_length           - buffer length (0 = full space)
//            gain                  - unsigned Q8.8 gain
//            mem_ready, mem_data   - memory read-valid / read data
//            memory_re, address_out- memory read request / address
//            data_out, data_valid  - scaled sample and its update pulse
//            busy                  - FSM not idle
//            timeout_err, overrun  - sticky error flags
//  Rev     : 1.0  initial release
// ============================================================================
module playback_reader
  import memory_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int GAIN_FRAC_BITS = DEFAULT_GAIN_FRAC_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  adc_clock,
  input  logic                  loop,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [ADDR_WIDTH-1:0] delay_reverb,
  input  logic [ADDR_WIDTH-1:0] loop_length,
  input  logic [15:0]           gain,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  memory_re,
  output logic [ADDR_WIDTH-1:0] address_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  timeout_err,
  output logic                  overrun
);

  localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Last count value: memory_re stays high for exactly TIMEOUT_CYCLES cycles
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  localparam logic signed [32:0] SAT_MAX = 33'sd32767;
  localparam logic signed [32:0] SAT_MIN = -33'sd32768;

  reader_state_t         r_state;
  logic [15:0]           r_gain;
  logic [DATA_WIDTH-1:0] r_sample;
  logic [DATA_WIDTH-1:0] r_scaled;
  logic [TIMER_W-1:0]    r_timer;

  logic                  w_tick;
  logic [ADDR_WIDTH-1:0] w_delay;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic signed [32:0]    w_prod;
  logic signed [32:0]    w_shift;
  logic [DATA_WIDTH-1:0] w_sat;

  sample_tick_sync u_tick_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (adc_clock),
    .tick     (w_tick)
  );

  // Read address behind the writer, wrapping inside the active loop region.
  // With loop_length == 0 the natural 16-bit wrap of the subtraction already
  // covers the full address space.
  always_comb begin
    w_delay = delay_reverb;
    if ((loop_length != '0) && (delay_reverb >= loop_length)) begin
      w_delay = loop_length - 1'b1;
    end
    if ((loop_length == '0) || (write_addr >= w_delay)) begin
      w_addr = write_addr - w_delay;
    end else begin
      w_addr = write_addr + loop_length - w_delay;
    end
  end

  // Signed sample x unsigned gain: the gain gets a zero sign bit so the
  // 33-bit signed multiply treats it as non-negative.
  always_comb begin
    w_prod  = $signed({{17{r_sample[DATA_WIDTH-1]}}, r_sample}) *
              $signed({17'd0, r_gain});
    w_shift = w_prod >>> GAIN_FRAC_BITS;
    if (w_shift > SAT_MAX) begin
      w_sat = 16'h7FFF;
    end else if (w_shift < SAT_MIN) begin
      w_sat = 16'h8000;
    end else begin
      w_sat = w_shift[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_gain      <= '0;
      r_sample    <= '0;
      r_scaled    <= '0;
      r_timer     <= '0;
      memory_re   <= 1'b0;
      address_out <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      data_valid <= 1'b0;

      if (w_tick && (r_state != ST_IDLE)) begin
        overrun <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_tick && loop) begin
            address_out <= w_addr;
            r_gain      <= gain;
            r_timer     <= '0;
            memory_re   <= 1'b1;
            busy        <= 1'b1;
            r_state     <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (mem_ready) begin
            r_sample  <= mem_data;
            memory_re <= 1'b0;
            r_state   <= ST_SCALE;
          end else if (r_timer == TIMER_LAST) begin
            timeout_err <= 1'b1;
            memory_re   <= 1'b0;
            busy        <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        ST_SCALE: begin
          r_scaled <= w_sat;
          r_state  <= ST_OUT;
        end

        ST_OUT: begin
          data_out   <= r_scaled;
          data_valid <= 1'b1;
          busy       <= 1'b0;
          r_state    <= ST_IDLE;
        end

        default: begin
          memory_re <= 1'b0;
          busy      <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : playback_reader
`default_nettype wire
